// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of the multiplexed 7-segment interface.
// It synchronises the digit select and segment pattern, and waits for each
// pair to stay stable. It then decodes the pattern into an 8-digit shadow
// register and flags completed frames and illegal patterns.
module seg_scan_capture #(
   parameter int STABLE_CYC = 16,
   parameter int CW         = 8
) (
   input  logic        CP,
   input  logic        CR,
   input  logic [2:0]  DIG_SEL,
   input  logic [6:0]  SEG,
   input  logic        CLR_ERR,
   output logic [31:0] DIGITS,
   output logic [7:0]  DIG_VALID,
   output logic        NEW,
   output logic        FRAME,
   output logic        ERR
);

   typedef enum logic [1:0] {TRACK, COMMIT, HOLD} state_t;

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_sel_m, r_sel_s;
   logic [6:0]    r_seg_m, r_seg_s;
   logic [9:0]    r_prev, r_cmt;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_exp;
   logic [31:0]   r_digits;
   logic [7:0]    r_valid;
   logic          r_new, r_frame, r_err;

   logic [9:0]    w_s;
   logic          w_same, w_commit;
   logic [2:0]    w_csel;
   logic [3:0]    w_dec_val;
   logic          w_dec_ok, w_dec_ovr;

   assign w_s      = {r_sel_s, r_seg_s};
   assign w_same   = (w_s == r_prev);
   assign w_commit = (r_state == COMMIT);
   // r_prev holds the sample that completed the stability window, so decode
   // that rather than a sample that may already be moving.
   assign w_csel   = r_prev[9:7];

   // two-flop synchronisers on the asynchronous display pins
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         r_sel_m <= '0;
         r_sel_s <= '0;
         r_seg_m <= '0;
         r_seg_s <= '0;
      end else begin
         r_sel_m <= DIG_SEL;
         r_sel_s <= r_sel_m;
         r_seg_m <= SEG;
         r_seg_s <= r_seg_m;
      end
   end

   // previous-sample register and stability counter
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_prev <= w_s;
         case (r_state)
            TRACK:   r_cnt <= w_same ? r_cnt + 1'b1 : '0;
            HOLD:    if (w_s != r_cmt) r_cnt <= '0;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // state register
   always_ff @(posedge CP or posedge CR) begin
      if (CR) r_state <= TRACK;
      else    r_state <= w_state_nxt;
   end

   // next state: commit once per stable run, then hold until the sample moves
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TRACK:   if (w_same && r_cnt == CW'(STABLE_CYC - 2)) w_state_nxt = COMMIT;
         COMMIT:  w_state_nxt = HOLD;
         HOLD:    if (w_s != r_cmt) w_state_nxt = TRACK;
         default: w_state_nxt = TRACK;
      endcase
   end

   // segment pattern (a..g) back to a digit value
   always_comb begin
      w_dec_val = 4'h0;
      w_dec_ok  = 1'b1;
      w_dec_ovr = 1'b0;
      case (r_prev[6:0])
         7'b1111110: w_dec_val = 4'd0;
         7'b0110000: w_dec_val = 4'd1;
         7'b1101101: w_dec_val = 4'd2;
         7'b1111001: w_dec_val = 4'd3;
         7'b0110011: w_dec_val = 4'd4;
         7'b1011011: w_dec_val = 4'd5;
         7'b1011111: w_dec_val = 4'd6;
         7'b1110000: w_dec_val = 4'd7;
         7'b1111111: w_dec_val = 4'd8;
         7'b1111011: w_dec_val = 4'd9;
         7'b1100011: begin
            w_dec_val = 4'hF;
            w_dec_ok  = 1'b0;
            w_dec_ovr = 1'b1;
         end
         default:    w_dec_ok = 1'b0;
      endcase
   end

   // commit: shadow register, frame tracker, pulses and sticky error
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         r_cmt    <= '0;
         r_exp    <= '0;
         r_digits <= '0;
         r_valid  <= '0;
         r_new    <= 1'b0;
         r_frame  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_new   <= w_commit;
         r_frame <= 1'b0;
         if (w_commit) begin
            r_cmt <= r_prev;
            if (w_dec_ok || w_dec_ovr) begin
               r_digits[{w_csel, 2'b00} +: 4] <= w_dec_val;
               r_valid[w_csel]                <= w_dec_ok;
            end
            // frame needs an unbroken 0..7 run; a stray 0 restarts it at 1
            if (w_csel == r_exp) begin
               r_exp <= r_exp + 3'd1;
               if (w_csel == 3'd7) r_frame <= 1'b1;
            end else begin
               r_exp <= (w_csel == 3'd0) ? 3'd1 : 3'd0;
            end
         end
         // a simultaneous illegal commit beats the clear
         if (w_commit && !(w_dec_ok || w_dec_ovr)) r_err <= 1'b1;
         else if (CLR_ERR)                          r_err <= 1'b0;
      end
   end

   assign DIGITS    = r_digits;
   assign DIG_VALID = r_valid;
   assign NEW       = r_new;
   assign FRAME     = r_frame;
   assign ERR       = r_err;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios followed by random pin
// activity. Outputs are compared every cycle against a sample-run-length
// reference model.
module tb_seg_scan_capture;
   localparam int STABLE = 16;

   logic        CP = 1'b0;
   logic        CR = 1'b0;
   logic [2:0]  DIG_SEL = '0;
   logic [6:0]  SEG = '0;
   logic        CLR_ERR = 1'b0;
   logic [31:0] DIGITS;
   logic [7:0]  DIG_VALID;
   logic        NEW, FRAME, ERR;

   seg_scan_capture #(.STABLE_CYC(STABLE), .CW(8)) dut (
      .CP(CP), .CR(CR), .DIG_SEL(DIG_SEL), .SEG(SEG), .CLR_ERR(CLR_ERR),
      .DIGITS(DIGITS), .DIG_VALID(DIG_VALID), .NEW(NEW), .FRAME(FRAME), .ERR(ERR)
   );

   always #5 CP = ~CP;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // segment patterns for digits 0..9
   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   localparam logic [6:0] OVR = 7'b1100011;

   // reference model: the sample seen by the design is the pin value two
   // clocks earlier; a digit commits once a run of equal samples reaches
   // STABLE, and shows up on the outputs one clock later.
   logic [9:0] m_hist[$];
   logic [9:0] m_last, m_pval, m_s;
   int         m_run;
   logic       m_pend, m_new, m_frame, m_err, m_hit;
   logic [3:0] m_dig [8];
   logic [7:0] m_val;
   int         m_seq[$];
   bit         m_ill, m_ok;

   function automatic logic [31:0] m_digits();
      logic [31:0] r = '0;
      for (int k = 0; k < 8; k++) r[4*k +: 4] = m_dig[k];
      return r;
   endfunction

   always @(posedge CP or posedge CR) begin
      if (CR) begin
         m_hist = {10'd0, 10'd0};
         m_last = '0; m_run = 1; m_pend = 0; m_pval = '0;
         m_new = 0; m_frame = 0; m_err = 0; m_val = '0;
         for (int k = 0; k < 8; k++) m_dig[k] = '0;
         m_seq = {};
      end else begin
         m_new = m_pend; m_frame = 0; m_ill = 0;
         if (m_pend) begin
            m_hit = 0;
            for (int d = 0; d < 10; d++)
               if (pat[d] == m_pval[6:0]) begin
                  m_dig[m_pval[9:7]] = 4'(d); m_val[m_pval[9:7]] = 1'b1; m_hit = 1;
               end
            if (!m_hit) begin
               if (m_pval[6:0] == OVR) begin
                  m_dig[m_pval[9:7]] = 4'hF; m_val[m_pval[9:7]] = 1'b0;
               end else m_ill = 1;
            end
            m_seq.push_back(int'(m_pval[9:7]));
            if (m_seq.size() > 8) void'(m_seq.pop_front());
            m_ok = (m_seq.size() == 8);
            for (int i = 0; i < m_seq.size(); i++) if (m_seq[i] != i) m_ok = 0;
            m_frame = m_ok;
         end
         if (m_ill) m_err = 1; else if (CLR_ERR) m_err = 0;
         m_s = m_hist.pop_front();
         m_hist.push_back({DIG_SEL, SEG});
         if (m_s == m_last) m_run++; else m_run = 1;
         m_last = m_s;
         m_pend = (m_run == STABLE);
         m_pval = m_s;
      end
   end

   int new_cnt, frame_cnt, new_at;

   task automatic tick();
      @(posedge CP);
      @(negedge CP);
      chk("new", 32'(NEW), 32'(m_new));
      chk("frame", 32'(FRAME), 32'(m_frame));
      chk("digits", DIGITS, m_digits());
      chk("valid", 32'(DIG_VALID), 32'(m_val));
      chk("err", 32'(ERR), 32'(m_err));
      if (NEW) new_cnt++;
      if (FRAME) frame_cnt++;
   endtask

   task automatic drive(input logic [2:0] s, input logic [6:0] g, input int n);
      DIG_SEL = s; SEG = g; new_at = -1;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (NEW && new_at < 0) new_at = i;
      end
   endtask

   logic [2:0]  r_sel;
   logic [6:0]  r_seg;
   logic [9:0]  cur;
   int          dur;

   initial begin
      #1 CR = 1'b1;
      tick(); tick();
      chk("rst_digits", DIGITS, 32'h0);
      chk("rst_flags", {29'd0, NEW, FRAME, ERR}, 32'h0);
      chk("rst_valid", 32'(DIG_VALID), 32'h0);

      // single stable digit
      DIG_SEL = 3'd3; SEG = pat[5]; CR = 1'b0;
      new_cnt = 0;
      drive(3'd3, pat[5], 30);
      chk("t1_new_cnt", new_cnt, 1);
      chk("t1_new_at", new_at, 19);
      chk("t1_nib3", 32'(DIGITS[15:12]), 32'd5);
      chk("t1_valid", 32'(DIG_VALID), 32'h08);

      // ascending sweep with digits 7..0
      new_cnt = 0; frame_cnt = 0;
      for (int k = 0; k < 8; k++) drive(3'(k), pat[7-k], 40);
      chk("sweep_new", new_cnt, 8);
      chk("sweep_frame", frame_cnt, 1);
      chk("sweep_digits", DIGITS, 32'h01234567);
      chk("sweep_valid", 32'(DIG_VALID), 32'hFF);

      // short-lived patterns never commit
      new_cnt = 0;
      for (int k = 0; k < 6; k++) drive(3'd2, k[0] ? pat[2] : pat[1], 10);
      chk("glitch_new", new_cnt, 0);
      chk("glitch_digits", DIGITS, 32'h01234567);
      drive(3'd2, pat[3], 20);
      chk("glitch_commit", new_at, 19);
      chk("glitch_nib2", 32'(DIGITS[11:8]), 32'd3);

      // illegal pattern, clear racing a second illegal commit, then clear alone
      drive(3'd1, 7'b0000001, 25);
      chk("ill_err", 32'(ERR), 32'd1);
      chk("ill_nib1", 32'(DIGITS[7:4]), 32'd6);
      DIG_SEL = 3'd1; SEG = 7'b0000010;
      for (int i = 1; i <= 22; i++) begin
         CLR_ERR = (i == 19);
         tick();
         if (i == 19) begin
            chk("race_new", 32'(NEW), 32'd1);
            chk("race_err", 32'(ERR), 32'd1);
         end
      end
      CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
      chk("clr_err", 32'(ERR), 32'd0);

      // broken sweep never frames; over-range marker on digit 4
      frame_cnt = 0;
      drive(3'd0, pat[0], 25); drive(3'd1, pat[1], 25); drive(3'd2, pat[2], 25);
      drive(3'd5, pat[5], 25); drive(3'd6, pat[6], 25); drive(3'd7, pat[7], 25);
      chk("ooo_frame", frame_cnt, 0);
      drive(3'd4, OVR, 25);
      chk("ovr_nib4", 32'(DIGITS[19:16]), 32'hF);
      chk("ovr_valid4", 32'(DIG_VALID[4]), 32'd0);

      // reset in the middle of a stability count
      drive(3'd6, pat[8], 10);
      CR = 1'b1; #1;
      chk("arst_digits", DIGITS, 32'h0);
      chk("arst_flags", {21'd0, DIG_VALID, NEW, FRAME, ERR}, 32'h0);
      tick(); tick();
      CR = 1'b0;
      new_cnt = 0;
      drive(3'd6, pat[8], 30);
      chk("arst_new_at", new_at, 19);
      chk("arst_new_cnt", new_cnt, 1);

      // random activity: glitches, long holds, legal/over-range/illegal codes
      cur = {DIG_SEL, SEG};
      for (int n = 0; n < 60; n++) begin
         do begin
            r_sel = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
               0:       r_seg = OVR;
               1:       r_seg = 7'($urandom);
               default: r_seg = pat[$urandom_range(0, 9)];
            endcase
         end while ({r_sel, r_seg} == cur);
         cur = {r_sel, r_seg};
         dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : $urandom_range(20, 45);
         DIG_SEL = r_sel; SEG = r_seg;
         for (int i = 0; i < dur; i++) begin
            CLR_ERR = ($urandom_range(0, 7) == 0);
            tick();
         end
         CLR_ERR = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receiving end of the multiplexed 7-segment display interface: consumes the 3-bit digit select and 7-bit segment pattern that our counter/decoder blocks drive.
- Waits until each select/segment pair is stable, decodes the pattern back to a 4-bit value, and stores it in an 8-digit shadow register.
- Flags frame completion and illegal patterns.
- Used for self-check of display paths on board and as a capture front-end for the display test bench.

Parameters:
- STABLE_CYC, 16, consecutive identical synchronised samples required before a digit is committed (legal range 2..255).
- CW, 8, width of the stability counter (must hold STABLE_CYC-1).

Ports:
- CP  input  1  system clock, all logic on rising edge.
- CR  input  1  asynchronous active-high reset.
- DIG_SEL  input  3  digit select from the display driver, asynchronous to CP.
- SEG  input  7  segment pattern, bit6=a … bit0=g, active-high, asynchronous to CP.
- CLR_ERR  input  1  synchronous clear of ERR.
- DIGITS  output  32  captured digits, nibble k (bits 4k+3:4k) = digit k.
- DIG_VALID  output  8  bit k set when digit k holds a decoded 0-9 value.
- NEW  output  1  one-cycle pulse on every commit.
- FRAME  output  1  one-cycle pulse when digits 0..7 have been committed in order.
- ERR  output  1  sticky illegal-pattern flag.

Behaviour:
- Reset (CR=1, async): sync flops, sample regs, counter, expected index = 0; state TRACK; DIGITS=0, DIG_VALID=0, NEW=0, FRAME=0, ERR=0.
- Input sync: DIG_SEL and SEG each pass through 2 flops. The synchronised sample S = {sel, seg} lags the pins by 2 cycles.
- TRACK state:
  - If S differs from the previous S, cnt←0.
  - Otherwise cnt←cnt+1.
  - When S equals the previous S and cnt==STABLE_CYC-2, go to COMMIT. S has then been stable STABLE_CYC cycles.
- COMMIT (1 cycle): decode seg, update the digit at index sel, assert NEW, latch S as committed value C, go to HOLD.
- HOLD: stay while S==C (no re-commit of an unchanged digit). When S≠C, cnt←0 and go to TRACK.
- Decode table:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9: nibble←value, DIG_VALID[sel]←1.
  - 1100011 (over-range marker): nibble←4'hF, DIG_VALID[sel]←0.
  - Any other pattern: nibble and DIG_VALID[sel] unchanged, ERR←1. NEW still pulses.
- Worst-case latency from a pin change to NEW: 2 + STABLE_CYC + 1 cycles. With the default, a pin change at cycle 0 gives NEW at cycle 19.
- Frame tracking, on each COMMIT with expected index E:
  - If sel==E: E←E+1. If sel==7, FRAME pulses with NEW and E←0.
  - If sel≠E: E←1 if sel==0, else E←0.
  - FRAME requires a strictly ascending 0..7 sweep; select wraps 7→0 naturally.
- ERR: set by an illegal pattern. Cleared by CLR_ERR only when no illegal commit occurs the same cycle; a simultaneous set wins.
- Glitches: any S change before STABLE_CYC is reached restarts the count, and nothing is written.
- Reset mid-operation: everything returns to reset values immediately. The first commit after release needs a full stability window.
- The last digit written is held indefinitely if inputs freeze.

Test Plan:
- Reset then drive sel=3, seg=1011011 for 30 cycles -> exactly one NEW, 19 cycles after the change; DIGITS[15:12]=5, DIG_VALID=8'h08, ERR=0.
- Sweep sel 0..7 with patterns for 7,6,5,4,3,2,1,0, 40 cycles each -> 8 NEW pulses; FRAME pulses on the 8th, coincident with NEW; DIGITS=32'h01234567, DIG_VALID=8'hFF.
- sel=2 stable, seg toggling every 10 cycles (< STABLE_CYC) -> no NEW, DIGITS unchanged; then hold 1111001 for 20 cycles -> NEW, DIGITS[11:8]=3.
- sel=1 with seg=0000001 held -> NEW, ERR=1, digit 1 unchanged. Assert CLR_ERR in the same cycle as a second illegal commit -> ERR stays 1. CLR_ERR alone -> ERR=0 next cycle.
- Out-of-order sweep 0,1,2,5,6,7 -> no FRAME. Over-range 1100011 on sel=4 -> nibble 4 = F, DIG_VALID[4]=0.
- Assert CR during a stability count -> all outputs 0 asynchronously. After release, the same stable input commits only after a full 19-cycle window.
